// File: rtl/mem_responder_if.sv
// ============================================================================
// Module : mem_responder_if
// Brief  : Request/response bus between the core and its byte-wide RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_responder_if #(
    parameter int ADDRW = 16
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic             req_burst;
    logic [ADDRW-1:0] req_addr;
    logic [7:0]       req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;

    modport master (
        output req_valid, req_write, req_burst, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_burst, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module : mem_responder
// Brief  : Byte RAM answering single reads/writes and 4-byte fetch bursts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int RAMSIZE = 64,
    parameter int ADDRW   = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mem_responder_if.slave  bus
);

    localparam int AW = (RAMSIZE > 4) ? $clog2(RAMSIZE) : 2;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RD    = 2'd1;
    localparam logic [1:0] c_BURST = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [ADDRW-1:0] c_RAMSIZE = ADDRW'(RAMSIZE);
    localparam logic [AW:0]      c_WRAP    = (AW+1)'(RAMSIZE);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic          r_ready;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_cnt;
    logic [31:0]   r_rsp_data;
    logic          r_rsp_err;
    logic [7:0]    r_ram [RAMSIZE];

    logic          w_accept;
    logic          w_oor;
    logic [AW:0]   w_sum;
    logic [AW:0]   w_wrap;
    logic [AW-1:0] w_idx;
    logic [7:0]    w_rd_byte;

    // r_ready is only ever set when the next state is IDLE, so it also implies IDLE.
    assign w_accept  = r_ready && bus.req_valid;
    assign w_oor     = (bus.req_addr >= c_RAMSIZE);

    // Burst address wraps modulo RAMSIZE; works for non-power-of-two sizes too.
    assign w_sum     = {1'b0, r_addr} + (AW+1)'(r_cnt);
    assign w_wrap    = w_sum - c_WRAP;
    assign w_idx     = (w_sum >= c_WRAP) ? w_wrap[AW-1:0] : w_sum[AW-1:0];
    assign w_rd_byte = r_ram[w_idx];

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = (r_state == c_RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_oor || bus.req_write) w_next_state = c_RESP;
                    else if (bus.req_burst)     w_next_state = c_BURST;
                    else                        w_next_state = c_RD;
                end
            end
            c_RD:    w_next_state = c_RESP;
            c_BURST: if (r_cnt == 2'd3) w_next_state = c_RESP;
            c_RESP:  if (bus.rsp_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_ready    <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= 2'd0;
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == c_IDLE);
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_addr <= bus.req_addr[AW-1:0];
                        r_cnt  <= 2'd0;
                        if (w_oor) begin
                            r_rsp_data <= 32'd0;
                            r_rsp_err  <= 1'b1;
                        end else if (bus.req_write) begin
                            r_rsp_data <= 32'd0;
                            r_rsp_err  <= 1'b0;
                        end
                    end
                end
                c_RD: begin
                    r_rsp_data <= {24'd0, w_rd_byte};
                end
                c_BURST: begin
                    r_rsp_data[{r_cnt, 3'b000} +: 8] <= w_rd_byte;
                    r_cnt <= r_cnt + 2'd1;
                end
                c_RESP: begin
                    if (bus.rsp_ready) r_rsp_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // RAM is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_write && !w_oor)
            r_ram[bus.req_addr[AW-1:0]] <= bus.req_wdata;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module : tb_mem_responder
// Brief  : Directed self-checking bench for mem_responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    mem_responder_if #(.ADDRW(16)) bus ();

    mem_responder #(.RAMSIZE(64), .ADDRW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and check latency (edges after accept), data and error.
    // With rsp_ready high the response is consumed at the following edge.
    task automatic do_req(input string tag, input logic wr, input logic bu,
                          input logic [15:0] addr, input logic [7:0] wd,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat);
        int lat;
        int guard;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_burst = bu;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_acc"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'hDEAD;
        bus.req_wdata = 8'hEE;
        lat = 0;
        while (!bus.rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, bus.rsp_data, exp_data);
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        if (bus.rsp_ready) begin
            @(posedge clk);
            #1;
            chk({tag, "_vdrop"}, 32'(bus.rsp_valid), 32'd0);
            chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
        end
    endtask

    logic [31:0] held;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_burst = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_rel_ready_low", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_rel_ready", 32'(bus.req_ready), 32'd1);

        // Fetch word assembly
        do_req("wr0", 1'b1, 1'b0, 16'd0, 8'h02, 32'd0, 1'b0, 0);
        do_req("wr1", 1'b1, 1'b0, 16'd1, 8'h00, 32'd0, 1'b0, 0);
        do_req("wr2", 1'b1, 1'b0, 16'd2, 8'h10, 32'd0, 1'b0, 0);
        do_req("wr3", 1'b1, 1'b0, 16'd3, 8'h00, 32'd0, 1'b0, 0);
        do_req("burst0", 1'b0, 1'b1, 16'd0, 8'h00, 32'h0010_0002, 1'b0, 4);

        // Single byte
        do_req("wr17", 1'b1, 1'b0, 16'd17, 8'hAB, 32'd0, 1'b0, 0);
        do_req("rd17", 1'b0, 1'b0, 16'd17, 8'h00, 32'h0000_00AB, 1'b0, 1);

        // Wrapping burst
        do_req("wr62", 1'b1, 1'b0, 16'd62, 8'h11, 32'd0, 1'b0, 0);
        do_req("wr63", 1'b1, 1'b0, 16'd63, 8'h22, 32'd0, 1'b0, 0);
        do_req("wr0b", 1'b1, 1'b0, 16'd0,  8'h33, 32'd0, 1'b0, 0);
        do_req("wr1b", 1'b1, 1'b0, 16'd1,  8'h44, 32'd0, 1'b0, 0);
        do_req("burst62", 1'b0, 1'b1, 16'd62, 8'h00, 32'h4433_2211, 1'b0, 4);

        // Out of range
        do_req("oor_rd64", 1'b0, 1'b0, 16'd64, 8'h00, 32'd0, 1'b1, 0);
        do_req("oor_wrffff", 1'b1, 1'b0, 16'hFFFF, 8'h55, 32'd0, 1'b1, 0);
        do_req("oor_burst", 1'b0, 1'b1, 16'h0100, 8'h00, 32'd0, 1'b1, 0);
        do_req("rd0_after_oor", 1'b0, 1'b0, 16'd0, 8'h00, 32'h0000_0033, 1'b0, 1);
        do_req("rd63_after_oor", 1'b0, 1'b0, 16'd63, 8'h00, 32'h0000_0022, 1'b0, 1);

        // Stalled response: bytes at 0..3 are 33,44,10,00
        bus.rsp_ready = 1'b0;
        do_req("stall", 1'b0, 1'b1, 16'd0, 8'h00, 32'h0010_4433, 1'b0, 4);
        held = bus.rsp_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_data", bus.rsp_data, 32'h0010_4433);
            chk("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_vdrop", 32'(bus.rsp_valid), 32'd0);
        chk("stall_rdy", 32'(bus.req_ready), 32'd1);
        chk("stall_data_hold", bus.rsp_data, held);

        // Reset two cycles into a burst
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_burst = 1'b1;
        bus.req_addr  = 16'd16;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("abort_acc", 32'(bus.req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_rel_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        do_req("keep17", 1'b0, 1'b0, 16'd17, 8'h00, 32'h0000_00AB, 1'b0, 1);
        do_req("keep62", 1'b0, 1'b1, 16'd62, 8'h00, 32'h4433_2211, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
